// File: rtl/conv_cfg_pkg.sv
// Shared schedule constants, FSM encoding and config decode for the conv input-fetch path.
// Pure declarations; no logic state.
package conv_cfg_pkg;

    localparam int PASS_CYC = 34;
    localparam int W_CYC    = 2;
    localparam int I_CYC    = 32;
    localparam int ROWS     = 61;
    localparam int FMAP_W   = 64;
    localparam int KNL_SZ   = 16;
    localparam int FMAP_SZ  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    // Channel/kernel count from the 3-bit pin code; codes above 3 saturate at 32.
    function automatic logic [5:0] cfg_decode(input logic [2:0] code);
        logic [5:0] n;
        case (code)
            3'd0:    n = 6'd8;
            3'd1:    n = 6'd16;
            3'd2:    n = 6'd24;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/conv_fetch_addr.sv
// Weight and fmap read-address generation from the schedule counters.
// Latency: purely combinational. Backpressure: none, follows the counters.
module conv_fetch_addr
    import conv_cfg_pkg::*;
(
    input  logic [4:0]  knl,
    input  logic [4:0]  chnl,
    input  logic [5:0]  row,
    input  logic [5:0]  cyc,
    input  logic [5:0]  ci,
    output logic [13:0] waddr,
    output logic [16:0] faddr
);

    // Each weight read moves KNL_SZ/W_CYC words; each fmap read moves FMAP_W/I_CYC columns.
    always_comb begin
        waddr = 14'((32'(knl) * 32'(ci) + 32'(chnl)) * KNL_SZ
                    + 32'(cyc) * (KNL_SZ / W_CYC));
        faddr = 17'(32'(chnl) * FMAP_SZ + 32'(row) * FMAP_W
                    + 32'(cyc) * (FMAP_W / I_CYC));
    end

endmodule

// File: rtl/conv_fetch_ctrl.sv
// Input-fetch sequencer: walks kernel/row/channel/cycle and issues read strobes (+ addresses when FETCH_ADDR_EN).
// Latency: first strobe the cycle after start is sampled; position/address outputs are registered decodes.
// Backpressure: in_hold freezes the schedule and drops both strobes combinationally in the same cycle.
module conv_fetch_ctrl
    import conv_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_start_conv,
    input  logic [2:0]  in_cfg_ci,
    input  logic [2:0]  in_cfg_co,
    input  logic        in_hold,
    output logic        out_readw_ctl,
    output logic        out_readi_ctl,
    output logic [13:0] out_waddr,
    output logic [16:0] out_faddr,
    output logic [4:0]  out_knl,
    output logic [4:0]  out_chnl,
    output logic [5:0]  out_row,
    output logic [5:0]  out_cyc,
    output logic        out_first_chnl,
    output logic        out_last_chnl,
    output logic        out_end_conv
);

    fetch_state_t state_q, state_d;
    logic [5:0]   ci_q, ci_d, co_q, co_d;
    logic [4:0]   knl_q, knl_d, chnl_q, chnl_d;
    logic [5:0]   row_q, row_d, cyc_q, cyc_d;
    logic         end_q, end_d;
    logic         run, adv, cyc_last, chnl_last, row_last, knl_last, sched_last;

    always_comb begin
        run        = (state_q == ST_RUN);
        adv        = run & ~in_hold;
        cyc_last   = (cyc_q == 6'(PASS_CYC - 1));
        chnl_last  = ({1'b0, chnl_q} == (ci_q - 6'd1));
        row_last   = (row_q == 6'(ROWS - 1));
        knl_last   = ({1'b0, knl_q} == (co_q - 6'd1));
        sched_last = cyc_last & chnl_last & row_last & knl_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ci_q    <= '0;
            co_q    <= '0;
            knl_q   <= '0;
            chnl_q  <= '0;
            row_q   <= '0;
            cyc_q   <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ci_q    <= ci_d;
            co_q    <= co_d;
            knl_q   <= knl_d;
            chnl_q  <= chnl_d;
            row_q   <= row_d;
            cyc_q   <= cyc_d;
            end_q   <= end_d;
        end
    end

    // DONE is left only once start drops, so a level start cannot re-trigger.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_start_conv)     state_d = ST_RUN;
            ST_RUN:  if (adv && sched_last) state_d = ST_DONE;
            ST_DONE: if (!in_start_conv)    state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ci_d   = ci_q;
        co_d   = co_q;
        knl_d  = knl_q;
        chnl_d = chnl_q;
        row_d  = row_q;
        cyc_d  = cyc_q;
        end_d  = 1'b0;
        if (state_q == ST_IDLE && in_start_conv) begin
            ci_d   = cfg_decode(in_cfg_ci);
            co_d   = cfg_decode(in_cfg_co);
            knl_d  = '0;
            chnl_d = '0;
            row_d  = '0;
            cyc_d  = '0;
        end else if (adv) begin
            cyc_d = cyc_q + 6'd1;
            if (cyc_last) begin
                cyc_d  = '0;
                chnl_d = chnl_q + 5'd1;
                if (chnl_last) begin
                    chnl_d = '0;
                    row_d  = row_q + 6'd1;
                    if (row_last) begin
                        row_d = '0;
                        knl_d = knl_q + 5'd1;
                        if (knl_last) begin
                            knl_d = '0;
                            end_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        out_readw_ctl  = adv & (cyc_q < 6'(W_CYC));
        out_readi_ctl  = adv & (cyc_q < 6'(I_CYC));
        out_first_chnl = run & (chnl_q == 5'd0);
        out_last_chnl  = run & chnl_last;
    end

    assign out_knl      = knl_q;
    assign out_chnl     = chnl_q;
    assign out_row      = row_q;
    assign out_cyc      = cyc_q;
    assign out_end_conv = end_q;

`ifdef FETCH_ADDR_EN
    conv_fetch_addr u_addr (
        .knl   (knl_q),
        .chnl  (chnl_q),
        .row   (row_q),
        .cyc   (cyc_q),
        .ci    (ci_q),
        .waddr (out_waddr),
        .faddr (out_faddr)
    );
`else
    assign out_waddr = '0;
    assign out_faddr = '0;
`endif

endmodule

// File: tb/tb_conv_fetch_ctrl.sv
// Bench for conv_fetch_ctrl: random hold/config noise against a linear-step schedule model.
`timescale 1ns/1ps
module tb_conv_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_start_conv;
    logic [2:0]  in_cfg_ci;
    logic [2:0]  in_cfg_co;
    logic        in_hold;
    logic        out_readw_ctl;
    logic        out_readi_ctl;
    logic [13:0] out_waddr;
    logic [16:0] out_faddr;
    logic [4:0]  out_knl;
    logic [4:0]  out_chnl;
    logic [5:0]  out_row;
    logic [5:0]  out_cyc;
    logic        out_first_chnl;
    logic        out_last_chnl;
    logic        out_end_conv;

    int n_chk = 0;
    int n_err = 0;

    conv_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_start_conv  (in_start_conv),
        .in_cfg_ci      (in_cfg_ci),
        .in_cfg_co      (in_cfg_co),
        .in_hold        (in_hold),
        .out_readw_ctl  (out_readw_ctl),
        .out_readi_ctl  (out_readi_ctl),
        .out_waddr      (out_waddr),
        .out_faddr      (out_faddr),
        .out_knl        (out_knl),
        .out_chnl       (out_chnl),
        .out_row        (out_row),
        .out_cyc        (out_cyc),
        .out_first_chnl (out_first_chnl),
        .out_last_chnl  (out_last_chnl),
        .out_end_conv   (out_end_conv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dec(input logic [2:0] code);
        return (code > 3'd3) ? 32 : (int'(code) + 1) * 8;
    endfunction

    task automatic check_zero(input string pfx);
        chk({pfx, "_readw"}, 32'(out_readw_ctl), 0);
        chk({pfx, "_readi"}, 32'(out_readi_ctl), 0);
        chk({pfx, "_waddr"}, 32'(out_waddr), 0);
        chk({pfx, "_faddr"}, 32'(out_faddr), 0);
        chk({pfx, "_knl"},   32'(out_knl), 0);
        chk({pfx, "_chnl"},  32'(out_chnl), 0);
        chk({pfx, "_row"},   32'(out_row), 0);
        chk({pfx, "_cyc"},   32'(out_cyc), 0);
        chk({pfx, "_first"}, 32'(out_first_chnl), 0);
        chk({pfx, "_last"},  32'(out_last_chnl), 0);
        chk({pfx, "_end"},   32'(out_end_conv), 0);
    endtask

    // Expected position after s un-held RUN cycles, decomposed from the flat step count.
    task automatic check_pos(input int s, input int ci, input bit h);
        int cyc, chnl, row, knl, wa, fa;
        cyc  = s % 34;
        chnl = (s / 34) % ci;
        row  = (s / (34 * ci)) % 61;
        knl  = s / (34 * ci * 61);
`ifdef FETCH_ADDR_EN
        wa = knl * ci * 16 + chnl * 16 + cyc * 8;
        fa = chnl * 4096 + row * 64 + cyc * 2;
`else
        wa = 0;
        fa = 0;
`endif
        chk("cyc",   32'(out_cyc), cyc);
        chk("chnl",  32'(out_chnl), chnl);
        chk("row",   32'(out_row), row);
        chk("knl",   32'(out_knl), knl);
        chk("readw", 32'(out_readw_ctl), (cyc < 2 && !h) ? 1 : 0);
        chk("readi", 32'(out_readi_ctl), (cyc < 32 && !h) ? 1 : 0);
        chk("first", 32'(out_first_chnl), (chnl == 0) ? 1 : 0);
        chk("last",  32'(out_last_chnl), (chnl == ci - 1) ? 1 : 0);
        chk("end",   32'(out_end_conv), 0);
        chk("waddr", 32'(out_waddr), wa);
        chk("faddr", 32'(out_faddr), fa);
    endtask

    // Start a run and follow it for stop_at steps (or to completion when stop_at < 0).
    task automatic do_run(input logic [2:0] ci_code, input logic [2:0] co_code,
                          input int hold_pct, input int stop_at, output int s_out);
        int ci, co, total, s, hold_left;
        bit h;
        ci = dec(ci_code);
        co = dec(co_code);
        total = co * 61 * ci * 34;
        @(negedge clk);
        rst_n = 1'b1;
        in_cfg_ci = ci_code;
        in_cfg_co = co_code;
        in_start_conv = 1'b1;
        in_hold = 1'b1;
        #1 check_zero("idle");
        s = 0;
        hold_left = 3;
        while (s < total && (stop_at < 0 || s < stop_at)) begin
            @(negedge clk);
            in_cfg_ci = 3'($urandom);
            in_cfg_co = 3'($urandom);
            if (s == 5 && hold_left > 0) begin
                h = 1'b1;
                hold_left--;
            end else begin
                h = ($urandom_range(99) < hold_pct);
            end
            in_hold = h;
            #1 check_pos(s, ci, h);
            if (!h) s++;
        end
        s_out = s;
    endtask

    task automatic finish_run();
        @(negedge clk);
        in_hold = 1'($urandom);
        #1;
        chk("done_end",   32'(out_end_conv), 1);
        chk("done_readw", 32'(out_readw_ctl), 0);
        chk("done_readi", 32'(out_readi_ctl), 0);
        in_hold = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("hold_start_end",   32'(out_end_conv), 0);
            chk("hold_start_readw", 32'(out_readw_ctl), 0);
            chk("hold_start_readi", 32'(out_readi_ctl), 0);
        end
        in_start_conv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check_zero("after_done");
    endtask

    task automatic abort_run(input int s, input int ci);
        @(negedge clk);
        in_hold = 1'b0;
        #1 check_pos(s, ci, 1'b0);
        rst_n = 1'b0;
        #1 check_zero("abort");
        in_start_conv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            #1;
            chk("post_abort_end",   32'(out_end_conv), 0);
            chk("post_abort_readi", 32'(out_readi_ctl), 0);
        end
    endtask

    initial begin
        int s;
        rst_n = 1'b0;
        in_start_conv = 1'b1;
        in_cfg_ci = 3'd0;
        in_cfg_co = 3'd0;
        in_hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 check_zero("rst");
        end

        do_run(3'd0, 3'd0, 8, -1, s);
        finish_run();

        do_run(3'd0, 3'd0, 8, 836, s);
        abort_run(s, 8);

        do_run(3'd7, 3'd5, 8, 1200, s);
        abort_run(s, 32);

        do_run(3'd0, 3'd1, 5, 16692, s);
        abort_run(s, 8);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
